// File: rtl/button_decoder_pkg.sv
// Shared constants for the button decoder: hold FSM encoding,
// counter width and parameter defaults.
package button_decoder_pkg;

    localparam int unsigned CNT_W = 16;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESSED = 2'd1;
    localparam logic [1:0] ST_HELD    = 2'd2;

    localparam int unsigned DEF_NUM_BTN      = 4;
    localparam int unsigned DEF_DEBOUNCE     = 20;
    localparam int unsigned DEF_LONG_TICKS   = 100;
    localparam int unsigned DEF_REPEAT_TICKS = 25;

endpackage

// File: rtl/button_decoder_if.sv
// Button pins, time base and per-channel event outputs.
// master drives pins/tick, slave is the decoder.
interface button_decoder_if
    import button_decoder_pkg::*;
#(
    parameter int unsigned NUM_BTN = DEF_NUM_BTN
) ();

    logic               tick;
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] level_o;
    logic [NUM_BTN-1:0] press_o;
    logic [NUM_BTN-1:0] short_o;
    logic [NUM_BTN-1:0] long_o;
    logic [NUM_BTN-1:0] repeat_o;

    modport master (
        output tick,
        output btn_raw,
        input  level_o,
        input  press_o,
        input  short_o,
        input  long_o,
        input  repeat_o
    );

    modport slave (
        input  tick,
        input  btn_raw,
        output level_o,
        output press_o,
        output short_o,
        output long_o,
        output repeat_o
    );

endinterface

// File: rtl/button_decoder_channel.sv
// One button channel: 2-flop synchronizer, debounce counter
// and press/short/long/repeat hold FSM.
module button_channel
    import button_decoder_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = DEF_DEBOUNCE,
    parameter int unsigned LONG_TICKS     = DEF_LONG_TICKS,
    parameter int unsigned REPEAT_TICKS   = DEF_REPEAT_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_short,
    output logic o_long,
    output logic o_repeat
);

    localparam logic [CNT_W-1:0] DB_CNT   = CNT_W'(DEBOUNCE_TICKS);
    localparam logic [CNT_W-1:0] LONG_CNT = CNT_W'(LONG_TICKS);
    localparam logic [CNT_W-1:0] REP_CNT  = CNT_W'(REPEAT_TICKS);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic             r_s1;
    logic             r_s2;
    logic             r_level;
    logic             r_press;
    logic             r_short;
    logic             r_long;
    logic             r_rep;
    logic [CNT_W-1:0] r_db;
    logic [CNT_W-1:0] r_hold;
    logic [CNT_W-1:0] r_rpt;
    logic [1:0]       r_state;

    logic             w_diff;
    logic             w_flip;
    logic             w_rise;
    logic             w_fall;
    logic [CNT_W-1:0] w_hold_nx;
    logic [CNT_W-1:0] w_rpt_nx;

    // Threshold match toggles the level without waiting for a tick,
    // which gives DEBOUNCE_TICKS=0 its one-cycle follow behaviour.
    assign w_diff    = r_s2 != r_level;
    assign w_flip    = w_diff && (r_db == DB_CNT);
    assign w_rise    = w_flip && !r_level;
    assign w_fall    = w_flip && r_level;
    assign w_hold_nx = r_hold + ONE;
    assign w_rpt_nx  = r_rpt + ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_short <= 1'b0;
            r_long  <= 1'b0;
            r_rep   <= 1'b0;
            r_db    <= '0;
            r_hold  <= '0;
            r_rpt   <= '0;
            r_state <= ST_IDLE;
        end else begin
            r_s1    <= i_raw;
            r_s2    <= r_s1;
            r_press <= 1'b0;
            r_short <= 1'b0;
            r_long  <= 1'b0;
            r_rep   <= 1'b0;

            if (!w_diff) begin
                r_db <= '0;
            end else if (w_flip) begin
                r_db    <= '0;
                r_level <= !r_level;
            end else if (i_tick) begin
                r_db <= r_db + ONE;
            end

            // A release always beats a long/repeat threshold.
            unique case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_press <= 1'b1;
                        r_hold  <= '0;
                        r_state <= ST_PRESSED;
                    end
                end
                ST_PRESSED: begin
                    if (w_fall) begin
                        r_short <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (i_tick) begin
                        if (w_hold_nx == LONG_CNT) begin
                            r_long  <= 1'b1;
                            r_rpt   <= '0;
                            r_state <= ST_HELD;
                        end else begin
                            r_hold <= w_hold_nx;
                        end
                    end
                end
                ST_HELD: begin
                    if (w_fall) begin
                        r_state <= ST_IDLE;
                    end else if (i_tick) begin
                        if (w_rpt_nx == REP_CNT) begin
                            r_rep <= 1'b1;
                            r_rpt <= '0;
                        end else begin
                            r_rpt <= w_rpt_nx;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_level  = r_level;
    assign o_press  = r_press;
    assign o_short  = r_short;
    assign o_long   = r_long;
    assign o_repeat = r_rep;

endmodule

// File: rtl/button_decoder.sv
// Multi-channel button decoder: NUM_BTN independent
// button_channel instances behind one interface.
module button_decoder
    import button_decoder_pkg::*;
#(
    parameter int unsigned NUM_BTN        = DEF_NUM_BTN,
    parameter int unsigned DEBOUNCE_TICKS = DEF_DEBOUNCE,
    parameter int unsigned LONG_TICKS     = DEF_LONG_TICKS,
    parameter int unsigned REPEAT_TICKS   = DEF_REPEAT_TICKS
) (
    input  logic              clk,
    input  logic              rst,
    button_decoder_if.slave   bus
);

    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] w_press;
    logic [NUM_BTN-1:0] w_short;
    logic [NUM_BTN-1:0] w_long;
    logic [NUM_BTN-1:0] w_repeat;

    for (genvar i = 0; i < int'(NUM_BTN); i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .LONG_TICKS     (LONG_TICKS),
            .REPEAT_TICKS   (REPEAT_TICKS)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .i_tick   (bus.tick),
            .i_raw    (bus.btn_raw[i]),
            .o_level  (w_level[i]),
            .o_press  (w_press[i]),
            .o_short  (w_short[i]),
            .o_long   (w_long[i]),
            .o_repeat (w_repeat[i])
        );
    end

    assign bus.level_o  = w_level;
    assign bus.press_o  = w_press;
    assign bus.short_o  = w_short;
    assign bus.long_o   = w_long;
    assign bus.repeat_o = w_repeat;

endmodule

// File: tb/tb_button_decoder.sv
// Bench for button_decoder: directed timing scenarios plus random
// pin activity, checked each cycle against a tick-count reference model.
module tb_button_decoder;

    localparam int NA = 4;
    localparam int NB = 2;
    localparam int NM = NA + NB;

    logic          clk = 1'b0;
    logic          rst;
    logic          tick;
    logic [NA-1:0] raw;

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int tick_mode = 0;

    always #5 clk = ~clk;

    button_decoder_if #(.NUM_BTN(NA)) bus_a ();
    button_decoder_if #(.NUM_BTN(NB)) bus_b ();

    assign bus_a.tick    = tick;
    assign bus_a.btn_raw = raw;
    assign bus_b.tick    = tick;
    assign bus_b.btn_raw = {raw[3], raw[0]};

    button_decoder #(
        .NUM_BTN(NA), .DEBOUNCE_TICKS(4),
        .LONG_TICKS(10), .REPEAT_TICKS(3)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    button_decoder #(
        .NUM_BTN(NB), .DEBOUNCE_TICKS(0),
        .LONG_TICKS(3), .REPEAT_TICKS(2)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    // Reference model: the stable level flips once the synced pin has
    // disagreed for DB ticks; events derive from ticks elapsed since press.
    bit m_s1[NM], m_s2[NM], m_lvl[NM], m_pressed[NM];
    int m_streak[NM], m_held[NM];
    bit e_press[NM], e_short[NM], e_long[NM], e_rep[NM];

    function automatic int db_of(input int c);
        return (c < NA) ? 4 : 0;
    endfunction

    function automatic int long_of(input int c);
        return (c < NA) ? 10 : 3;
    endfunction

    function automatic int rep_of(input int c);
        return (c < NA) ? 3 : 2;
    endfunction

    function automatic bit raw_of(input int c);
        bit r;
        if (c < NA) r = raw[c];
        else if (c == NA) r = raw[0];
        else r = raw[3];
        return r;
    endfunction

    task automatic model_step(input int c);
        bit rise, fall, pin;
        int over;
        pin = raw_of(c);
        rise = 0;
        fall = 0;
        e_press[c] = 0;
        e_short[c] = 0;
        e_long[c]  = 0;
        e_rep[c]   = 0;
        if (rst) begin
            m_s1[c] = 0;
            m_s2[c] = 0;
            m_lvl[c] = 0;
            m_streak[c] = 0;
            m_pressed[c] = 0;
            m_held[c] = 0;
        end else begin
            if (m_s2[c] == m_lvl[c]) begin
                m_streak[c] = 0;
            end else if (m_streak[c] == db_of(c)) begin
                m_lvl[c] = m_s2[c];
                m_streak[c] = 0;
                rise = m_lvl[c];
                fall = !m_lvl[c];
            end else if (tick) begin
                m_streak[c]++;
            end
            m_s2[c] = m_s1[c];
            m_s1[c] = pin;
            if (rise) begin
                e_press[c] = 1;
                m_pressed[c] = 1;
                m_held[c] = 0;
            end else if (fall) begin
                e_short[c] = m_pressed[c] && (m_held[c] < long_of(c));
                m_pressed[c] = 0;
            end else if (m_pressed[c] && tick) begin
                m_held[c]++;
                over = m_held[c] - long_of(c);
                if (over == 0) e_long[c] = 1;
                else if (over > 0 && (over % rep_of(c)) == 0) e_rep[c] = 1;
            end
        end
    endtask

    always @(posedge clk) begin
        for (int c = 0; c < NM; c++) model_step(c);
    end

    function automatic logic [4:0] dut_vec(input int c);
        logic [4:0] v;
        if (c < NA)
            v = {bus_a.level_o[c], bus_a.press_o[c], bus_a.short_o[c],
                 bus_a.long_o[c], bus_a.repeat_o[c]};
        else
            v = {bus_b.level_o[c-NA], bus_b.press_o[c-NA],
                 bus_b.short_o[c-NA], bus_b.long_o[c-NA],
                 bus_b.repeat_o[c-NA]};
        return v;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic [4:0] got, exp;
        for (int c = 0; c < NM; c++) begin
            got = dut_vec(c);
            exp = {m_lvl[c], e_press[c], e_short[c], e_long[c], e_rep[c]};
            n_asserts++;
            assert (got === exp) else begin
                n_fail++;
                $error("FAIL model_ch%0d cyc%0d: observed %b expected %b",
                       c, cyc, got, exp);
            end
            n_asserts++;
            assert ($countones(got[3:0]) <= 1) else begin
                n_fail++;
                $error("FAIL onehot_ch%0d: observed %b expected <=1 pulse",
                       c, got[3:0]);
            end
        end
    endtask

    task automatic step();
        unique case (tick_mode)
            1:       tick = (cyc % 4 == 0);
            2:       tick = 1'($urandom_range(0, 1));
            default: tick = 1'b1;
        endcase
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_all();
    endtask

    task automatic wait_evt(input int c, input int b, input int lim,
                            output int k);
        logic [4:0] v;
        k = 0;
        do begin
            step();
            k++;
            v = dut_vec(c);
        end while (!v[b] && k < lim);
    endtask

    task automatic run_count(input int c, input int n, output int np,
                             output int ns, output int nl, output int nr);
        logic [4:0] v;
        np = 0; ns = 0; nl = 0; nr = 0;
        for (int i = 0; i < n; i++) begin
            step();
            v = dut_vec(c);
            np += int'(v[3]);
            ns += int'(v[2]);
            nl += int'(v[1]);
            nr += int'(v[0]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, np, ns, nl, nr, acc;
        int idx;
        rst = 1'b1;
        tick = 1'b1;
        raw = '0;
        step();
        step();
        chk("reset_a", int'({bus_a.level_o, bus_a.press_o, bus_a.short_o,
                             bus_a.long_o, bus_a.repeat_o}), 0);
        chk("reset_b", int'({bus_b.level_o, bus_b.press_o, bus_b.short_o,
                             bus_b.long_o, bus_b.repeat_o}), 0);
        rst = 1'b0;
        step();

        // press latency, long press and repeats on channel 0
        raw[0] = 1'b1;
        wait_evt(0, 3, 20, k);
        chk("press_latency", k, 7);
        chk("press_level", int'(bus_a.level_o[0]), 1);
        run_count(0, 30, np, ns, nl, nr);
        chk("hold_long_cnt", nl, 1);
        chk("hold_rep_cnt", nr, 6);
        raw[0] = 1'b0;
        run_count(0, 12, np, ns, nl, nr);
        chk("held_release_short", ns, 0);
        chk("held_release_level", int'(bus_a.level_o[0]), 0);

        // bounce on channel 1, then a short press
        raw[1] = 1'b1;
        run_count(1, 3, np, ns, nl, nr);
        acc = np;
        raw[1] = 1'b0;
        run_count(1, 2, np, ns, nl, nr);
        acc += np;
        raw[1] = 1'b1;
        wait_evt(1, 3, 20, k);
        chk("bounce_no_early_press", acc, 0);
        chk("bounce_latency", k, 7);
        raw[1] = 1'b0;
        run_count(1, 15, np, ns, nl, nr);
        chk("short_cnt", ns, 1);
        chk("short_no_long", nl, 0);
        chk("short_no_press", np, 0);

        // one tick in four on channel 3 (and DB=0 channel on dut_b)
        tick_mode = 1;
        raw[3] = 1'b1;
        wait_evt(5, 4, 10, k);
        chk("db0_latency", k, 3);
        wait_evt(3, 3, 60, k);
        chk("slow_press_seen", int'(bus_a.press_o[3]), 1);
        wait_evt(3, 1, 60, k);
        chk("slow_long_seen", int'(bus_a.long_o[3]), 1);
        wait_evt(3, 0, 30, k);
        chk("slow_rep_gap1", k, 12);
        wait_evt(3, 0, 30, k);
        chk("slow_rep_gap2", k, 12);
        raw[3] = 1'b0;
        run_count(3, 60, np, ns, nl, nr);
        chk("slow_release_short", ns, 0);
        chk("slow_release_level", int'(bus_a.level_o[3]), 0);
        tick_mode = 0;

        // reset while channel 2 is in the held state
        raw[2] = 1'b1;
        wait_evt(2, 3, 20, k);
        chk("ch2_press_latency", k, 7);
        run_count(2, 12, np, ns, nl, nr);
        chk("ch2_long_cnt", nl, 1);
        rst = 1'b1;
        step();
        chk("midhold_reset_a", int'({bus_a.level_o, bus_a.press_o,
                                     bus_a.short_o, bus_a.long_o,
                                     bus_a.repeat_o}), 0);
        rst = 1'b0;
        wait_evt(2, 3, 20, k);
        chk("repress_latency", k, 7);
        raw[2] = 1'b0;
        run_count(2, 15, np, ns, nl, nr);
        chk("repress_short", ns, 1);

        // random pins and random tick
        tick_mode = 2;
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                idx = int'($urandom_range(0, NA - 1));
                raw[idx] = ~raw[idx];
            end
            step();
        end
        tick_mode = 0;
        raw = '0;
        for (int i = 0; i < 40; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/button_decoder.md
BUTTON_DECODER -- requirements
Module: button_decoder

Interface
REQ-001 Parameter NUM_BTN, default 4: number of independent button channels.
REQ-002 Parameter DEBOUNCE_TICKS, default 20: ticks a synchronized input must differ from the stable level before the stable level changes; range 0..65535.
REQ-003 Parameter LONG_TICKS, default 100: ticks of continuous press before a long-press event; range 1..65535.
REQ-004 Parameter REPEAT_TICKS, default 25: ticks between auto-repeat events after a long press; range 1..65535.
REQ-005 clk  in  1  single design clock; all state changes on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-007 tick  in  1  time-base enable; all tick counters advance only in cycles where tick=1.
REQ-008 btn_raw  in  NUM_BTN  asynchronous active-high button pins, one bit per channel.
REQ-009 level_o  out  NUM_BTN  debounced stable level per channel.
REQ-010 press_o  out  NUM_BTN  one-cycle pulse on debounced 0->1.
REQ-011 short_o  out  NUM_BTN  one-cycle pulse on debounced release when no long press occurred.
REQ-012 long_o  out  NUM_BTN  one-cycle pulse when hold time reaches LONG_TICKS.
REQ-013 repeat_o  out  NUM_BTN  one-cycle pulse every REPEAT_TICKS while held after long_o.

Function
REQ-014 Channels shall be fully independent; no event on one channel shall affect another.
REQ-015 Each btn_raw bit shall pass a 2-flop synchronizer; only the second flop output (sync) shall feed the logic.
REQ-016 Debounce counter (16 bit) shall clear in any cycle where sync equals level_o, and otherwise increment in cycles where tick=1.
REQ-017 When the debounce counter equals DEBOUNCE_TICKS and sync differs from level_o, level_o shall toggle and the counter shall clear in the same cycle.
REQ-018 With DEBOUNCE_TICKS=0, level_o shall follow sync with one cycle of latency, independent of tick.
REQ-019 A bounce (sync returning to level_o before threshold) shall clear the counter; level_o and all pulses shall remain unchanged.
REQ-020 press_o shall be registered and high in exactly the cycle in which level_o first reads 1.
REQ-021 Hold FSM states: IDLE (level 0), PRESSED (level 1, hold count below LONG_TICKS), HELD (long reached).
REQ-022 IDLE->PRESSED on debounced press; hold counter (16 bit) cleared.
REQ-023 In PRESSED, hold counter increments on tick; on reaching LONG_TICKS: long_o pulse, move to HELD, repeat counter cleared.
REQ-024 In HELD, repeat counter increments on tick; on reaching REPEAT_TICKS: repeat_o pulse and counter cleared; repeats continue indefinitely with no saturation of events.
REQ-025 Debounced release in PRESSED: short_o pulse, go IDLE; release in HELD: no pulse, go IDLE.
REQ-026 Release and long threshold in the same cycle: release wins; short_o pulses, long_o does not.
REQ-027 Release and repeat threshold in the same cycle: release wins; repeat_o does not pulse.
REQ-028 At most one of press_o, short_o, long_o, repeat_o shall be high per channel per cycle.

Reset
REQ-029 On rst=1: synchronizers, level_o, all pulse outputs, all counters cleared to 0; FSM to IDLE.
REQ-030 Reset asserted mid-press or mid-hold shall emit no pulse; after release of rst, a still-pressed button shall be debounced anew and produce press_o.

Structure
REQ-031 Package button_decoder_pkg shall hold the FSM state encoding (IDLE, PRESSED, HELD), the 16-bit counter width constant, and the parameter defaults.
REQ-032 One sub-module, button_channel (synchronizer, debounce, hold FSM for one bit), shall be instantiated NUM_BTN times by button_decoder.

Verification
REQ-033 DEBOUNCE_TICKS=4, tick=1 constantly; btn_raw[0] 0->1 held -> level_o[0]=1 and press_o[0] pulse exactly 7 cycles after the edge (2 sync + 5).
REQ-034 Bounce: btn_raw[1] high 3 cycles, low 2, high steady -> exactly one press_o[1], timed from the final rising edge.
REQ-035 LONG_TICKS=10, REPEAT_TICKS=3, hold 30 ticks -> one long_o, then repeat_o every 3 ticks; release -> no short_o.
REQ-036 Press then release after 5 ticks of hold (LONG_TICKS=10) -> one press_o, one short_o, no long_o.
REQ-037 tick asserted 1 cycle in 4 -> all debounce/hold/repeat timings scale by 4 exactly.
REQ-038 rst asserted while channel 2 in HELD -> all outputs 0 next cycle, no pulses; after rst deasserts with button still high -> fresh press_o after debounce.
